// File: rtl/shifter_frame_receiver.sv
// Two-lane serial shifter receiver: rebuilds each lane's byte from DS/CP/MR_N and pairs lanes into frames.
// Optional seven-segment digit decode of lane A is built when SHIFTER_RX_DECODE_EN is defined.
module shifter_frame_receiver #(
   parameter int IDLE_TIMEOUT       = 1024,
   parameter int IDLE_TIMEOUT_WIDTH = 11
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_a_ds,
   input  logic       i_a_cp,
   input  logic       i_a_mr_n,
   input  logic       i_b_ds,
   input  logic       i_b_cp,
   input  logic       i_b_mr_n,
   output logic [7:0] o_a_data,
   output logic [7:0] o_b_data,
   output logic       o_a_valid,
   output logic       o_b_valid,
   output logic       o_frame_valid,
   output logic       o_err,
   output logic [3:0] o_digit_value,
   output logic       o_digit_known
);

   localparam logic [IDLE_TIMEOUT_WIDTH-1:0] IDLE_LAST = IDLE_TIMEOUT_WIDTH'(IDLE_TIMEOUT - 1);

   logic [1:0] ds_pin;
   logic [1:0] cp_pin;
   logic [1:0] mr_pin;
   logic [1:0] lane_done;
   logic [1:0] lane_valid;
   logic [1:0] lane_err;
   logic [7:0] lane_data [2];

   assign ds_pin = {i_b_ds, i_a_ds};
   assign cp_pin = {i_b_cp, i_a_cp};
   assign mr_pin = {i_b_mr_n, i_a_mr_n};

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_lane
         logic                          ds_s1_reg, ds_s2_reg;
         logic                          cp_s1_reg, cp_s2_reg, cp_prev_reg;
         logic                          mr_s1_reg, mr_s2_reg;
         logic                          rise_reg, ds_d_reg;
         logic [7:0]                    shift_reg, shift_next;
         logic [7:0]                    data_reg, data_next;
         logic [2:0]                    cnt_reg, cnt_next;
         logic [IDLE_TIMEOUT_WIDTH-1:0] idle_reg, idle_next;
         logic                          valid_reg, valid_next;
         logic                          err_reg, err_next;

         // rise_reg/ds_d_reg add one stage after edge detection so DS and CP stay aligned
         always_ff @(posedge i_clk) begin
            if (i_reset) begin
               ds_s1_reg   <= 1'b0;
               ds_s2_reg   <= 1'b0;
               cp_s1_reg   <= 1'b0;
               cp_s2_reg   <= 1'b0;
               cp_prev_reg <= 1'b0;
               mr_s1_reg   <= 1'b0;
               mr_s2_reg   <= 1'b0;
               rise_reg    <= 1'b0;
               ds_d_reg    <= 1'b0;
               shift_reg   <= '0;
               data_reg    <= '0;
               cnt_reg     <= '0;
               idle_reg    <= '0;
               valid_reg   <= 1'b0;
               err_reg     <= 1'b0;
            end else begin
               ds_s1_reg   <= ds_pin[gi];
               ds_s2_reg   <= ds_s1_reg;
               cp_s1_reg   <= cp_pin[gi];
               cp_s2_reg   <= cp_s1_reg;
               cp_prev_reg <= cp_s2_reg;
               mr_s1_reg   <= mr_pin[gi];
               mr_s2_reg   <= mr_s1_reg;
               rise_reg    <= cp_s2_reg & ~cp_prev_reg;
               ds_d_reg    <= ds_s2_reg;
               shift_reg   <= shift_next;
               data_reg    <= data_next;
               cnt_reg     <= cnt_next;
               idle_reg    <= idle_next;
               valid_reg   <= valid_next;
               err_reg     <= err_next;
            end
         end

         always_comb begin
            shift_next = shift_reg;
            data_next  = data_reg;
            cnt_next   = cnt_reg;
            idle_next  = idle_reg;
            valid_next = 1'b0;
            err_next   = err_reg;
            if (!mr_s2_reg) begin
               shift_next = '0;
               cnt_next   = '0;
               idle_next  = '0;
               if (cnt_reg != 3'd0) begin
                  err_next = 1'b1;
               end
            end else if (rise_reg) begin
               shift_next = {shift_reg[6:0], ds_d_reg};
               cnt_next   = cnt_reg + 3'd1;
               idle_next  = '0;
               if (cnt_reg == 3'd7) begin
                  data_next  = {shift_reg[6:0], ds_d_reg};
                  valid_next = 1'b1;
               end
            end else if (cnt_reg != 3'd0) begin
               // a stalled partial byte is abandoned silently apart from the error flag
               if (idle_reg == IDLE_LAST) begin
                  shift_next = '0;
                  cnt_next   = '0;
                  idle_next  = '0;
                  err_next   = 1'b1;
               end else begin
                  idle_next = idle_reg + 1'b1;
               end
            end
         end

         assign lane_done[gi]  = valid_next;
         assign lane_valid[gi] = valid_reg;
         assign lane_err[gi]   = err_reg;
         assign lane_data[gi]  = data_reg;
      end
   endgenerate

   logic [1:0] pend_reg, pend_next;
   logic       frame_reg, frame_next;

   // a completion landing on the same cycle a frame fires is kept for the next frame
   always_comb begin
      frame_next = &pend_reg;
      pend_next  = ((&pend_reg) ? 2'b00 : pend_reg) | lane_done;
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         pend_reg  <= 2'b00;
         frame_reg <= 1'b0;
      end else begin
         pend_reg  <= pend_next;
         frame_reg <= frame_next;
      end
   end

   assign o_a_data      = lane_data[0];
   assign o_b_data      = lane_data[1];
   assign o_a_valid     = lane_valid[0];
   assign o_b_valid     = lane_valid[1];
   assign o_frame_valid = frame_reg;
   assign o_err         = |lane_err;

`ifdef SHIFTER_RX_DECODE_EN
   logic [3:0] digit_value_reg, digit_value_next;
   logic       digit_known_reg, digit_known_next;

   // segment order is bit0=a .. bit6=g; the decimal point is not part of the match
   always_comb begin
      digit_value_next = digit_value_reg;
      digit_known_next = digit_known_reg;
      if (lane_valid[0]) begin
         digit_value_next = 4'd0;
         digit_known_next = 1'b1;
         case (lane_data[0][6:0])
            7'h3F:   digit_value_next = 4'd0;
            7'h06:   digit_value_next = 4'd1;
            7'h5B:   digit_value_next = 4'd2;
            7'h4F:   digit_value_next = 4'd3;
            7'h66:   digit_value_next = 4'd4;
            7'h6D:   digit_value_next = 4'd5;
            7'h7D:   digit_value_next = 4'd6;
            7'h07:   digit_value_next = 4'd7;
            7'h7F:   digit_value_next = 4'd8;
            7'h6F:   digit_value_next = 4'd9;
            default: digit_known_next = 1'b0;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         digit_value_reg <= 4'd0;
         digit_known_reg <= 1'b0;
      end else begin
         digit_value_reg <= digit_value_next;
         digit_known_reg <= digit_known_next;
      end
   end

   assign o_digit_value = digit_value_reg;
   assign o_digit_known = digit_known_reg;
`else
   assign o_digit_value = 4'd0;
   assign o_digit_known = 1'b0;
`endif

endmodule

// File: tb/tb_shifter_frame_receiver.sv
// Scoreboard bench for shifter_frame_receiver: serial stimulus queues expected bytes, a negedge monitor checks them.
module tb_shifter_frame_receiver;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       a_ds = 1'b0, a_cp = 1'b0, a_mr_n = 1'b1;
   logic       b_ds = 1'b0, b_cp = 1'b0, b_mr_n = 1'b1;
   logic [7:0] o_a_data, o_b_data;
   logic       o_a_valid, o_b_valid, o_frame_valid, o_err;
   logic [3:0] o_digit_value;
   logic       o_digit_known;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   typedef struct {
      logic [7:0] data;
      int         due;
   } exp_t;

   exp_t q_a[$];
   exp_t q_b[$];
   bit   exp_err = 1'b0;

   localparam logic [6:0] PATS [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

   shifter_frame_receiver dut (
      .i_clk         (clk),
      .i_reset       (rst),
      .i_a_ds        (a_ds),
      .i_a_cp        (a_cp),
      .i_a_mr_n      (a_mr_n),
      .i_b_ds        (b_ds),
      .i_b_cp        (b_cp),
      .i_b_mr_n      (b_mr_n),
      .o_a_data      (o_a_data),
      .o_b_data      (o_b_data),
      .o_a_valid     (o_a_valid),
      .o_b_valid     (o_b_valid),
      .o_frame_valid (o_frame_valid),
      .o_err         (o_err),
      .o_digit_value (o_digit_value),
      .o_digit_known (o_digit_known)
   );

   always #20 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic void digit_of(input logic [7:0] d, output logic [3:0] v, output bit k);
      v = 4'd0;
      k = 1'b0;
`ifdef SHIFTER_RX_DECODE_EN
      for (int i = 0; i < 10; i++) begin
         if (d[6:0] == PATS[i]) begin
            v = 4'(i);
            k = 1'b1;
         end
      end
`endif
   endfunction

   // Shift the top nbits of each enabled byte, MSB first; a full byte queues its expectation.
   task automatic send(input bit en_a, input bit en_b, input logic [7:0] ba,
                       input logic [7:0] bb, input int nbits, input int half);
      int k;
      for (int i = 0; i < nbits; i++) begin
         @(posedge clk); #1;
         if (en_a) a_ds = ba[7-i];
         if (en_b) b_ds = bb[7-i];
         @(posedge clk); #1;
         if (en_a) a_cp = 1'b1;
         if (en_b) b_cp = 1'b1;
         k = cyc + 1;
         if (nbits == 8 && i == 7) begin
            if (en_a) q_a.push_back('{data: ba, due: k + 3});
            if (en_b) q_b.push_back('{data: bb, due: k + 3});
         end
         repeat (half) @(posedge clk);
         #1;
         a_cp = 1'b0;
         b_cp = 1'b0;
         repeat (half) @(posedge clk);
      end
   endtask

   task automatic pulse_reset();
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      exp_err = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      @(negedge clk);
      check({tag, "_a_data"}, o_a_data, 8'h00);
      check({tag, "_b_data"}, o_b_data, 8'h00);
      check({tag, "_valids"}, {o_a_valid, o_b_valid, o_frame_valid}, 3'b000);
      check({tag, "_err"}, o_err, 1'b0);
      check({tag, "_digit"}, {o_digit_known, o_digit_value}, 5'h00);
   endtask

   // Monitor: pops expectations on valid pulses and tracks frame pairing at transaction level.
   bit         pend_a = 0, pend_b = 0, fire_due = 0, dec_due = 0;
   logic [3:0] dec_val;
   bit         dec_known;
   exp_t       e;

   always @(negedge clk) begin
      if (rst) begin
         pend_a   = 0;
         pend_b   = 0;
         fire_due = 0;
         dec_due  = 0;
      end else begin
         if (dec_due) begin
            check("digit_value", o_digit_value, dec_val);
            check("digit_known", o_digit_known, dec_known);
            dec_due = 0;
         end
         if (o_frame_valid || fire_due) check("frame_valid", o_frame_valid, fire_due);
         if (fire_due) begin
            pend_a = 0;
            pend_b = 0;
         end
         if (o_a_valid) begin
            if (q_a.size() == 0) begin
               check("a_valid_unexpected", o_a_valid, 1'b0);
            end else begin
               e = q_a.pop_front();
               check("a_data", o_a_data, e.data);
               check("a_valid_cycle", cyc, e.due);
               digit_of(e.data, dec_val, dec_known);
               dec_due = 1;
               $display("lane A byte 0x%02h at cycle %0d", o_a_data, cyc);
            end
            pend_a = 1;
         end
         if (o_b_valid) begin
            if (q_b.size() == 0) begin
               check("b_valid_unexpected", o_b_valid, 1'b0);
            end else begin
               e = q_b.pop_front();
               check("b_data", o_b_data, e.data);
               check("b_valid_cycle", cyc, e.due);
               $display("lane B byte 0x%02h at cycle %0d", o_b_data, cyc);
            end
            pend_b = 1;
         end
         fire_due = pend_a && pend_b;
      end
   end

   initial begin
      #2400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] ra, rb;
      int         lane, half;

      repeat (3) @(posedge clk);
      check_all_zero("reset");
      @(posedge clk); #1;
      rst = 1'b0;

      // single lane A digit byte, 8-cycle CP period
      send(1, 0, 8'h6D, 8'h00, 8, 3);
      repeat (6) @(posedge clk);

      // both lanes in lockstep
      send(1, 1, 8'h3F, 8'h01, 8, 3);
      repeat (6) @(posedge clk);
      @(negedge clk);
      check("err_after_lockstep", o_err, exp_err);

      // lane B stalls mid-byte past the idle timeout
      send(0, 1, 8'h00, 8'hB3, 5, 3);
      repeat (1100) @(posedge clk);
      exp_err = 1'b1;
      @(negedge clk);
      check("err_after_timeout", o_err, exp_err);
      send(0, 1, 8'h00, 8'hA5, 8, 3);
      repeat (6) @(posedge clk);
      @(negedge clk);
      check("b_data_after_timeout", o_b_data, 8'hA5);

      pulse_reset();
      check_all_zero("post_reset");

      // MR_N asserted mid-byte on lane A
      send(1, 0, 8'hE0, 8'h00, 3, 3);
      repeat (3) @(posedge clk);
      #1 a_mr_n = 1'b0;
      repeat (4) @(posedge clk);
      #1 a_mr_n = 1'b1;
      exp_err = 1'b1;
      repeat (4) @(posedge clk);
      send(1, 0, 8'h06, 8'h00, 8, 3);
      repeat (6) @(posedge clk);
      @(negedge clk);
      check("err_after_mr", o_err, exp_err);
      check("a_data_after_mr", o_a_data, 8'h06);

      // reset while bit 6 is in flight drops the partial byte
      send(1, 0, 8'hC3, 8'h00, 6, 3);
      pulse_reset();
      check_all_zero("mid_byte_reset");
      send(1, 0, 8'h99, 8'h00, 8, 3);
      repeat (6) @(posedge clk);

      // non-digit pattern
      send(1, 0, 8'h55, 8'h00, 8, 3);
      repeat (6) @(posedge clk);

      for (int t = 0; t < 40; t++) begin
         lane = $urandom_range(0, 2);
         half = $urandom_range(3, 6);
         ra   = 8'($urandom_range(0, 255));
         rb   = 8'($urandom_range(0, 255));
         if ($urandom_range(0, 1) == 1) ra = {ra[7], PATS[$urandom_range(0, 9)]};
         send(lane != 1, lane != 0, ra, rb, 8, half);
         repeat ($urandom_range(0, 12)) @(posedge clk);
      end

      repeat (20) @(posedge clk);
      @(negedge clk);
      check("a_queue_drained", q_a.size(), 0);
      check("b_queue_drained", q_b.size(), 0);
      check("final_err", o_err, exp_err);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
